julia_mem_arbiter: RTL and testbench
====================================

// Module: julia_mem_arbiter
// PURPOSE
//  Shares the single frame-buffer write port between the NUM_WORKERS julia workers.
//  Round-robin arbitration over worker done requests; latches the winner's address/colour onto wr_addr/wr_data.
//  Holds wr_ready until the bus returns wr_done, then pulses mc_jw_done to the granted worker.
//  Sits beside dispatch in julia_wrapper, driving the mc_jw_busy/mc_jw_done worker nets.
// PARAMETERS
//  NUM_WORKERS  16  number of julia_worker requesters
//  ADDR_W       32  write address width
//  DATA_W       32  write data (colour) width
// PORTS
//  clk          in   1                       system clock, rising edge
//  rst          in   1                       reset, asynchronous, active-high
//  jw_mc_done   in   NUM_WORKERS             per-worker write request (pixel ready)
//  color_in     in   DATA_W x NUM_WORKERS    per-worker colour, valid while request high
//  addr_in      in   ADDR_W x NUM_WORKERS    per-worker pixel address, valid while request high
//  wr_done      in   1                       bus accepted current write
//  mc_jw_busy   out  NUM_WORKERS             all bits 1 while a write is in flight
//  mc_jw_done   out  NUM_WORKERS             one-hot, 1-cycle ack to the served worker
//  wr_addr      out  ADDR_W                  registered write address
//  wr_data      out  DATA_W                  registered write data
//  wr_ready     out  1                       write request to the bus
//  pixel_count  out  32                      completed writes (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1, async): state IDLE; all outputs 0; rr pointer 0; served mask 0. Mid-write reset aborts without ack.
//  FSM IDLE -> WRITE -> ACK -> IDLE.
//  IDLE: req = jw_mc_done & ~served_mask. If req!=0, grant = first set bit at/after pointer (wrap N-1 -> 0);
//    register wr_addr/wr_data from winner, wr_ready<=1, mc_jw_busy<='1, -> WRITE. wr_done ignored here.
//  WRITE: wr_ready held 1, wr_addr/wr_data stable. On wr_done: wr_ready<=0, mc_jw_done[grant]<=1, -> ACK.
//    Requester dropping jw_mc_done during WRITE does not cancel; latched data still written.
//  ACK: mc_jw_done cleared, mc_jw_busy<=0, pointer<=(grant+1) mod N, served_mask<=onehot(grant), -> IDLE.
//  served_mask is cleared after the first IDLE cycle, so a worker that drops its request one cycle
//    after mc_jw_done is never double-served.
//  Latency: request sampled in IDLE -> wr_ready high next cycle; wr_done -> mc_jw_done next cycle;
//    minimum 3 cycles per pixel plus bus wait.
//  wr_done held >1 cycle: only the first is counted (ACK/IDLE ignore wr_done).
//  grant index width $clog2(NUM_WORKERS); pointer wraps modulo NUM_WORKERS (non-power-of-2 legal).
// CONFIGURATION
//  JULIA_ARB_STATS_EN defined: pixel_count increments by 1 at each WRITE->ACK; wraps at 2^32; reset 0.
//  Not defined: pixel_count tied 0, no counter flops.
// STRUCTURE
//  julia_pkg: arb_state_t enum {IDLE, WRITE, ACK}; NUM_WORKERS_DEF=16 constant.
//  Sub-module julia_rr_pick: combinational rotate/priority-encode; inputs req, pointer;
//    outputs valid and grant index.
// TESTING
//  1 Worker 3 requests, addr 0x100, color 0xFF00FF00 -> next cycle wr_ready=1, wr_addr=0x100,
//    wr_data=0xFF00FF00; wr_done 2 cycles later -> mc_jw_done=16'h0008 for exactly 1 cycle.
//  2 Workers 0, 5, 15 request together, pointer 0 -> served 0, 5, 15 in order; each acked once.
//  3 Workers 2 and 7 request continuously -> grants alternate 2, 7, 2, 7; no worker starved.
//  4 rst asserted in WRITE -> wr_ready, mc_jw_busy 0 immediately and no mc_jw_done;
//    held request served after release with pointer at 0.
//  5 wr_done pulsed in IDLE -> no state change; wr_done held 4 cycles in WRITE -> exactly one ack.
//  6 With JULIA_ARB_STATS_EN, 3 writes -> pixel_count=3; without the macro pixel_count stays 0.

Source files
------------

// File: rtl/julia_pkg.sv
// Shared types and constants for the julia frame-buffer write arbiter.
package julia_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACK
    } arb_state_t;

    localparam int NUM_WORKERS_DEF = 16;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/julia_rr_pick.sv
// Round-robin pick: first set request at or after the pointer, wrapping N-1 -> 0.
module julia_rr_pick
    import julia_pkg::*;
#(
    parameter int N     = NUM_WORKERS_DEF,
    parameter int IDX_W = idx_w(NUM_WORKERS_DEF)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic             valid,
    output logic [IDX_W-1:0] grant
);

    always_comb begin
        valid = 1'b0;
        grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned idx;
            // Pointer is always below N, so one subtraction wraps non-power-of-2 counts.
            idx = 32'(pointer) + i;
            if (idx >= 32'(N)) idx = idx - 32'(N);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/julia_mem_arbiter.sv
// Shares the frame-buffer write port among julia workers with round-robin arbitration.
// Optional pixel counter enabled by defining JULIA_ARB_STATS_EN.
module julia_mem_arbiter
    import julia_pkg::*;
#(
    parameter int NUM_WORKERS = NUM_WORKERS_DEF,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WORKERS-1:0]        jw_mc_done,
    input  logic [NUM_WORKERS*DATA_W-1:0] color_in,
    input  logic [NUM_WORKERS*ADDR_W-1:0] addr_in,
    input  logic                          wr_done,
    output logic [NUM_WORKERS-1:0]        mc_jw_busy,
    output logic [NUM_WORKERS-1:0]        mc_jw_done,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic [31:0]                   pixel_count
);

    localparam int IDX_W = idx_w(NUM_WORKERS);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [NUM_WORKERS-1:0] mask_q, mask_d;
    logic [NUM_WORKERS-1:0] busy_d, done_d;
    logic [ADDR_W-1:0]      wr_addr_d;
    logic [DATA_W-1:0]      wr_data_d;
    logic                   wr_ready_d;

    logic [NUM_WORKERS-1:0] req;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_grant;

    assign req = jw_mc_done & ~mask_q;

    julia_rr_pick #(
        .N     (NUM_WORKERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .pointer (ptr_q),
        .valid   (pick_valid),
        .grant   (pick_grant)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        mask_d     = mask_q;
        busy_d     = mc_jw_busy;
        done_d     = mc_jw_done;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        wr_ready_d = wr_ready;
        case (state_q)
            IDLE: begin
                // The just-served worker is masked for this one cycle only.
                mask_d = '0;
                if (pick_valid) begin
                    grant_d    = pick_grant;
                    wr_addr_d  = addr_in[int'(pick_grant)*ADDR_W +: ADDR_W];
                    wr_data_d  = color_in[int'(pick_grant)*DATA_W +: DATA_W];
                    wr_ready_d = 1'b1;
                    busy_d     = '1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (wr_done) begin
                    wr_ready_d = 1'b0;
                    done_d     = NUM_WORKERS'(1) << grant_q;
                    state_d    = ACK;
                end
            end
            ACK: begin
                done_d  = '0;
                busy_d  = '0;
                ptr_d   = (grant_q == IDX_W'(NUM_WORKERS - 1)) ? '0 : grant_q + 1'b1;
                mask_d  = NUM_WORKERS'(1) << grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            mask_q     <= '0;
            mc_jw_busy <= '0;
            mc_jw_done <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_ready   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            mask_q     <= mask_d;
            mc_jw_busy <= busy_d;
            mc_jw_done <= done_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            wr_ready   <= wr_ready_d;
        end
    end

`ifdef JULIA_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_count <= '0;
        end else if (state_q == WRITE && wr_done) begin
            pixel_count <= pixel_count + 32'd1;
        end
    end
`else
    assign pixel_count = '0;
`endif

endmodule

// File: tb/tb_julia_mem_arbiter.sv
// Directed scoreboard bench for julia_mem_arbiter (16 workers, 32-bit address/data).
module tb_julia_mem_arbiter;

    localparam int NW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    jw_mc_done;
    logic [NW*32-1:0] color_in;
    logic [NW*32-1:0] addr_in;
    logic             wr_done;
    logic [NW-1:0]    mc_jw_busy;
    logic [NW-1:0]    mc_jw_done;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             wr_ready;
    logic [31:0]      pixel_count;

    julia_mem_arbiter #(
        .NUM_WORKERS (NW),
        .ADDR_W      (32),
        .DATA_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jw_mc_done  (jw_mc_done),
        .color_in    (color_in),
        .addr_in     (addr_in),
        .wr_done     (wr_done),
        .mc_jw_busy  (mc_jw_busy),
        .mc_jw_done  (mc_jw_done),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .pixel_count (pixel_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ack_count = 0;
    int   writes    = 0;
    int   cur_w     = 0;

    always @(posedge clk) if (mc_jw_done != '0) ack_count++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int w, input logic [31:0] a, input logic [31:0] d);
        addr_in[w*32 +: 32]  = a;
        color_in[w*32 +: 32] = d;
        jw_mc_done[w]        = 1'b1;
    endtask

    task automatic expect_grant(input int w);
        sb.push_back('{w, addr_in[w*32 +: 32], color_in[w*32 +: 32]});
    endtask

    task automatic pixel_chk(input string tag);
`ifdef JULIA_ARB_STATS_EN
        chk(tag, pixel_count, 64'(writes));
`else
        chk(tag, pixel_count, 64'd0);
`endif
    endtask

    // Waits (bounded) for the bus request and compares it with the scoreboard head.
    task automatic wait_write(output int lat);
        exp_t e;
        lat = 0;
        while (!wr_ready && lat < 40) begin
            tick();
            lat++;
        end
        if (!wr_ready) begin
            chk("wr_ready_timeout", 64'd0, 64'd1);
        end else if (sb.size() == 0) begin
            chk("unexpected_write", 64'd1, 64'd0);
        end else begin
            e     = sb.pop_front();
            cur_w = e.w;
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            chk("busy_write", mc_jw_busy, {NW{1'b1}});
            chk("done_idle_write", mc_jw_done, '0);
        end
    endtask

    task automatic ack(input int bus_wait, input int hold, input logic [NW-1:0] drop);
        logic [NW-1:0] onehot;
        onehot = '0;
        onehot[cur_w] = 1'b1;
        repeat (bus_wait) begin
            tick();
            chk("wr_ready_held", wr_ready, 1'b1);
        end
        wr_done = 1'b1;
        tick();
        writes++;
        chk("mc_jw_done", mc_jw_done, onehot);
        chk("wr_ready_drop", wr_ready, 1'b0);
        jw_mc_done = jw_mc_done & ~drop;
        if (hold <= 1) wr_done = 1'b0;
        tick();
        chk("done_one_cycle", mc_jw_done, '0);
        chk("busy_cleared", mc_jw_busy, '0);
        for (int i = 2; i < hold; i++) tick();
        wr_done = 1'b0;
    endtask

    initial begin
        int lat;
        int acks0;
        rst        = 1'b1;
        jw_mc_done = '0;
        color_in   = '0;
        addr_in    = '0;
        wr_done    = 1'b0;
        tick();
        tick();
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_busy", mc_jw_busy, '0);
        chk("rst_done", mc_jw_done, '0);
        chk("rst_wr_addr", wr_addr, '0);
        chk("rst_wr_data", wr_data, '0);
        chk("rst_pixel_count", pixel_count, '0);
        rst = 1'b0;
        tick();

        // 1: single worker, latency and one-cycle ack
        set_req(3, 32'h100, 32'hFF00FF00);
        expect_grant(3);
        wait_write(lat);
        chk("latency_1", 64'(lat), 64'd1);
        ack(2, 1, 16'h0008);
        chk("ack_total_t1", 64'(ack_count), 64'd1);

        // 2: three simultaneous requesters from pointer 0
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        writes = 0;
        set_req(0, 32'h1000, 32'hA0A0_0000);
        set_req(5, 32'h1005, 32'hA0A0_0005);
        set_req(15, 32'h100F, 32'hA0A0_000F);
        expect_grant(0);
        expect_grant(5);
        expect_grant(15);
        acks0 = ack_count;
        wait_write(lat);
        ack(0, 1, 16'h0001);
        wait_write(lat);
        ack(1, 1, 16'h0020);
        wait_write(lat);
        ack(0, 1, 16'h8000);
        tick();
        tick();
        chk("ack_total_t2", 64'(ack_count - acks0), 64'd3);
        chk("idle_after_t2", wr_ready, 1'b0);
        pixel_chk("pixel_count_3");

        // 3: two continuous requesters alternate
        set_req(2, 32'h2002, 32'hC0C0_0002);
        set_req(7, 32'h2007, 32'hC0C0_0007);
        expect_grant(2);
        expect_grant(7);
        expect_grant(2);
        expect_grant(7);
        wait_write(lat);
        ack(0, 1, '0);
        wait_write(lat);
        ack(0, 1, '0);
        wait_write(lat);
        ack(0, 1, '0);
        wait_write(lat);
        ack(0, 1, 16'h0084);
        tick();
        tick();
        chk("idle_after_t3", wr_ready, 1'b0);

        // 4: reset during WRITE aborts; pointer restarts at 0
        set_req(1, 32'h3001, 32'hD0D0_0001);
        set_req(9, 32'h3009, 32'hD0D0_0009);
        expect_grant(9);
        wait_write(lat);
        acks0 = ack_count;
        rst   = 1'b1;
        #1;
        chk("rst_mid_wr_ready", wr_ready, 1'b0);
        chk("rst_mid_busy", mc_jw_busy, '0);
        chk("rst_mid_done", mc_jw_done, '0);
        tick();
        tick();
        rst    = 1'b0;
        writes = 0;
        chk("rst_no_ack", 64'(ack_count - acks0), 64'd0);
        expect_grant(1);
        expect_grant(9);
        wait_write(lat);
        ack(0, 1, 16'h0002);
        wait_write(lat);
        ack(0, 1, 16'h0200);
        tick();

        // 5: wr_done ignored in IDLE; held wr_done acks once
        wr_done = 1'b1;
        tick();
        chk("idle_wr_done_ready", wr_ready, 1'b0);
        chk("idle_wr_done_done", mc_jw_done, '0);
        wr_done = 1'b0;
        tick();
        chk("idle_wr_done_busy", mc_jw_busy, '0);
        set_req(4, 32'h4004, 32'hE0E0_0004);
        expect_grant(4);
        acks0 = ack_count;
        wait_write(lat);
        chk("latency_5", 64'(lat), 64'd1);
        ack(1, 4, 16'h0010);
        tick();
        tick();
        chk("held_wr_done_acks", 64'(ack_count - acks0), 64'd1);
        chk("idle_after_t5", wr_ready, 1'b0);
        pixel_chk("pixel_count_end");
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
